// File: rtl/multi_edge_detect_if.sv
// multi_edge_detect_if: channel inputs, mode/enable/clear controls and
// status outputs of the multi-channel edge detector, bundled as one port.
// master: the controlling side (drives pins and controls, reads status).
// slave:  the edge detector itself.
interface multi_edge_detect_if #(
  parameter int CH = 8
);
  logic [CH-1:0]   din;
  logic [2*CH-1:0] mode;
  logic [CH-1:0]   irq_en;
  logic [CH-1:0]   clr;
  logic [CH-1:0]   level_o;
  logic [CH-1:0]   rise_o;
  logic [CH-1:0]   fall_o;
  logic [CH-1:0]   event_o;
  logic [CH-1:0]   pending_o;
  logic            irq_o;

  modport master (
    output din, mode, irq_en, clr,
    input  level_o, rise_o, fall_o, event_o, pending_o, irq_o
  );

  modport slave (
    input  din, mode, irq_en, clr,
    output level_o, rise_o, fall_o, event_o, pending_o, irq_o
  );
endinterface

// File: rtl/multi_edge_detect.sv
// multi_edge_detect: CH-channel edge detector for asynchronous pins.
// Each channel is synchronised, optionally glitch filtered, and produces
// rise/fall pulses, mode-qualified event pulses and a sticky pending flag.
// The OR of enabled pending flags drives a registered interrupt.
// Compile-time option: define MULTI_EDGE_FILTER_EN to build the per-channel
// glitch filter (FILTER_CYCLES honoured); otherwise the accepted level is
// the synchroniser output directly.
module multi_edge_detect #(
  parameter int CH            = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input logic                clk,
  input logic                rst,
  multi_edge_detect_if.slave bus
);
  localparam int PRIME_W = $clog2(SYNC_STAGES + 1);
`ifdef MULTI_EDGE_FILTER_EN
  localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
`endif

  logic [CH-1:0]      sync_s;
  logic [CH-1:0]      level;
  logic [CH-1:0]      level_d_reg;
  logic [PRIME_W-1:0] prime_cnt_reg;
  logic               primed_reg;
  logic               prime_now;
  logic [CH-1:0]      mode_rise;
  logic [CH-1:0]      mode_fall;
  logic [CH-1:0]      rise_next;
  logic [CH-1:0]      fall_next;
  logic [CH-1:0]      event_next;
  logic [CH-1:0]      pending_next;
  logic [CH-1:0]      rise_reg;
  logic [CH-1:0]      fall_reg;
  logic [CH-1:0]      event_reg;
  logic [CH-1:0]      pending_reg;
  logic               irq_reg;

  // The synchroniser chain is full once SYNC_STAGES edges have passed after
  // reset; the following edge loads the levels without generating pulses.
  assign prime_now = !primed_reg && (prime_cnt_reg == PRIME_W'(SYNC_STAGES));

  // Count synchroniser fill time after reset, then mark the block primed
  always_ff @(posedge clk) begin
    if (rst) begin
      prime_cnt_reg <= '0;
      primed_reg    <= 1'b0;
    end else if (prime_now) begin
      primed_reg <= 1'b1;
    end else if (!primed_reg) begin
      prime_cnt_reg <= prime_cnt_reg + PRIME_W'(1);
    end
  end

  genvar gi;
  generate
    // Parameter combinations outside the supported range are left unbuilt
    // here; they are rejected at integration review.
    if (SYNC_STAGES < 2 || FILTER_CYCLES < 1 || CH < 1 || CH > 32) begin : g_unsupported_params
    end

    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_reg;

      // Shift the asynchronous pin through the synchroniser chain
      always_ff @(posedge clk) begin
        if (rst) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.din[gi]};
        end
      end

      assign sync_s[gi]    = sync_reg[SYNC_STAGES-1];
      assign mode_rise[gi] = bus.mode[2*gi];
      assign mode_fall[gi] = bus.mode[2*gi+1];

`ifdef MULTI_EDGE_FILTER_EN
      logic [CNT_W-1:0] cnt_reg;
      logic             level_reg;

      // Accept a new level only after it has differed for FILTER_CYCLES
      // consecutive edges; any edge agreeing with the level discards the run
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg   <= '0;
          level_reg <= 1'b0;
        end else if (!primed_reg) begin
          cnt_reg <= '0;
          if (prime_now) begin
            level_reg <= sync_s[gi];
          end
        end else if (sync_s[gi] != level_reg) begin
          if (cnt_reg == CNT_W'(FILTER_CYCLES - 1)) begin
            level_reg <= sync_s[gi];
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end else begin
          cnt_reg <= '0;
        end
      end

      assign level[gi] = level_reg;
`else
      assign level[gi] = sync_s[gi];
`endif
    end
  endgenerate

  // Detect level transitions against last cycle's level; nothing fires
  // until primed so the initial pin state never looks like an edge
  always_comb begin
    rise_next    = {CH{primed_reg}} & level & ~level_d_reg;
    fall_next    = {CH{primed_reg}} & ~level & level_d_reg;
    event_next   = (rise_next & mode_rise) | (fall_next & mode_fall);
    // A new event outranks a clear strobe arriving on the same edge
    pending_next = event_next | (pending_reg & ~bus.clr);
  end

  // Register pulses, sticky pending flags and the interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      level_d_reg <= '0;
      rise_reg    <= '0;
      fall_reg    <= '0;
      event_reg   <= '0;
      pending_reg <= '0;
      irq_reg     <= 1'b0;
    end else begin
      // At the priming edge the filtered level is not yet loaded, so seed
      // the history directly from the synchroniser
      level_d_reg <= prime_now ? sync_s : level;
      rise_reg    <= rise_next;
      fall_reg    <= fall_next;
      event_reg   <= event_next;
      pending_reg <= pending_next;
      irq_reg     <= |(pending_reg & bus.irq_en);
    end
  end

  assign bus.level_o   = level;
  assign bus.rise_o    = rise_reg;
  assign bus.fall_o    = fall_reg;
  assign bus.event_o   = event_reg;
  assign bus.pending_o = pending_reg;
  assign bus.irq_o     = irq_reg;
endmodule

// File: tb/tb_multi_edge_detect.sv
// tb_multi_edge_detect: scoreboard bench for multi_edge_detect.
// Expected pulses are queued with their due cycle when stimulus is driven and
// popped when that cycle is reached; all other cycles must be pulse-free.
// Latency and minimum accepted width follow MULTI_EDGE_FILTER_EN.
module tb_multi_edge_detect;
  localparam int CH   = 8;
  localparam int SYNC = 2;
`ifdef MULTI_EDGE_FILTER_EN
  localparam int FILT = 4;
`else
  localparam int FILT = 0;
`endif
  // din change (driven between edges) to visible pulse, in edges
  localparam int LAT  = SYNC + FILT + 1;
  // shortest accepted pulse width
  localparam int HOLD = (FILT > 1) ? FILT : 1;

  typedef struct {
    int         cyc;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] evt;
  } exp_t;

  exp_t sb[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  multi_edge_detect_if #(.CH(CH)) bus ();

  multi_edge_detect #(
    .CH(CH),
    .SYNC_STAGES(SYNC),
    .FILTER_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // advance to the next falling edge (one rising edge in between)
  task automatic tick();
    @(negedge clk);
  endtask

  // queue an expected pulse set, kept sorted by cycle and merged per cycle
  function automatic void sb_push(input int c, input logic [7:0] r,
                                  input logic [7:0] f, input logic [7:0] e);
    exp_t item;
    int idx;
    idx = sb.size();
    for (int j = 0; j < sb.size(); j++) begin
      if (sb[j].cyc == c) begin
        item = sb[j];
        item.rise = item.rise | r;
        item.fall = item.fall | f;
        item.evt  = item.evt | e;
        sb[j] = item;
        return;
      end
      if (sb[j].cyc > c) begin
        idx = j;
        break;
      end
    end
    item = '{c, r, f, e};
    sb.insert(idx, item);
  endfunction

  task automatic test_reset();
    exp_t want;
    bus.din = 8'h08; bus.mode = 16'hFFFF; bus.irq_en = 8'h00; bus.clr = 8'h00;
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus.level_o, bus.rise_o, bus.fall_o, bus.event_o, bus.pending_o, bus.irq_o} !== 41'd0) begin
      errors++;
      $display("FAIL reset_state level=%h rise=%h fall=%h event=%h pending=%h irq=%b required all 0",
               bus.level_o, bus.rise_o, bus.fall_o, bus.event_o, bus.pending_o, bus.irq_o);
    end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      want = '{cyc, 8'h00, 8'h00, 8'h00};
      if (sb.size() > 0 && sb[0].cyc == cyc) want = sb.pop_front();
      checks++;
      if (bus.rise_o !== want.rise || bus.fall_o !== want.fall || bus.event_o !== want.evt) begin
        errors++;
        $display("FAIL prime_pulses cyc=%0d rise=%h/%h fall=%h/%h event=%h/%h (got/required)",
                 cyc, bus.rise_o, want.rise, bus.fall_o, want.fall, bus.event_o, want.evt);
      end
    end
    checks++;
    if (bus.level_o !== 8'h08 || bus.pending_o !== 8'h00) begin
      errors++;
      $display("FAIL prime_level level=%h required 08 pending=%h required 00", bus.level_o, bus.pending_o);
    end
    $display("test_reset done cyc=%0d", cyc);
  endtask

  task automatic test_single_rise();
    exp_t want;
    int n;
    n = cyc;
    sb_push(n + LAT, 8'h01, 8'h00, 8'h01);
    for (int k = 0; k < LAT + 4; k++) begin
      if (k == 0) bus.din[0] = 1'b1;
      tick();
      want = '{cyc, 8'h00, 8'h00, 8'h00};
      if (sb.size() > 0 && sb[0].cyc == cyc) want = sb.pop_front();
      checks++;
      if (bus.rise_o !== want.rise || bus.fall_o !== want.fall || bus.event_o !== want.evt) begin
        errors++;
        $display("FAIL single_rise cyc=%0d rise=%h/%h fall=%h/%h event=%h/%h (got/required)",
                 cyc, bus.rise_o, want.rise, bus.fall_o, want.fall, bus.event_o, want.evt);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL single_rise_timeout pending_expectations=%0d required 0", sb.size());
      sb.delete();
    end
    checks++;
    if (bus.level_o !== 8'h09 || bus.pending_o !== 8'h01 || bus.irq_o !== 1'b0) begin
      errors++;
      $display("FAIL single_rise_state level=%h/09 pending=%h/01 irq=%b/0 (got/required)",
               bus.level_o, bus.pending_o, bus.irq_o);
    end
    bus.clr = 8'hFF;
    tick();
    bus.clr = 8'h00;
    checks++;
    if (bus.pending_o !== 8'h00) begin
      errors++;
      $display("FAIL single_rise_clear pending=%h required 00", bus.pending_o);
    end
    $display("test_single_rise done cyc=%0d", cyc);
  endtask

  task automatic test_glitch();
    exp_t want;
    int n;
    n = cyc;
    // 3-cycle pulse: shorter than the filter window when the filter is built
    if (FILT <= 3) begin
      sb_push(n + LAT, 8'h02, 8'h00, 8'h02);
      sb_push(n + 3 + LAT, 8'h00, 8'h02, 8'h02);
    end
    // minimum-width pulse: always accepted
    sb_push(n + 20 + LAT, 8'h02, 8'h00, 8'h02);
    sb_push(n + 20 + HOLD + LAT, 8'h00, 8'h02, 8'h02);
    for (int k = 0; k < 20 + HOLD + LAT + 4; k++) begin
      if (k == 0) bus.din[1] = 1'b1;
      if (k == 3) bus.din[1] = 1'b0;
      if (k == 20) bus.din[1] = 1'b1;
      if (k == 20 + HOLD) bus.din[1] = 1'b0;
      tick();
      want = '{cyc, 8'h00, 8'h00, 8'h00};
      if (sb.size() > 0 && sb[0].cyc == cyc) want = sb.pop_front();
      checks++;
      if (bus.rise_o !== want.rise || bus.fall_o !== want.fall || bus.event_o !== want.evt) begin
        errors++;
        $display("FAIL glitch cyc=%0d rise=%h/%h fall=%h/%h event=%h/%h (got/required)",
                 cyc, bus.rise_o, want.rise, bus.fall_o, want.fall, bus.event_o, want.evt);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL glitch_timeout pending_expectations=%0d required 0", sb.size());
      sb.delete();
    end
    checks++;
    if (bus.level_o !== 8'h09 || bus.pending_o !== 8'h02) begin
      errors++;
      $display("FAIL glitch_state level=%h/09 pending=%h/02 (got/required)", bus.level_o, bus.pending_o);
    end
    bus.clr = 8'hFF;
    tick();
    bus.clr = 8'h00;
    $display("test_glitch done cyc=%0d", cyc);
  endtask

  task automatic test_mode_irq();
    exp_t want;
    int n, f;
    logic [7:0] want_pend;
    logic want_irq;
    bus.mode[5:4] = 2'b10;
    bus.irq_en = 8'h04;
    n = cyc;
    f = n + HOLD + 2 + LAT;
    sb_push(n + LAT, 8'h04, 8'h00, 8'h00);
    sb_push(f, 8'h00, 8'h04, 8'h04);
    for (int k = 0; k < HOLD + 2 + LAT + 4; k++) begin
      if (k == 0) bus.din[2] = 1'b1;
      if (k == HOLD + 2) bus.din[2] = 1'b0;
      tick();
      want = '{cyc, 8'h00, 8'h00, 8'h00};
      if (sb.size() > 0 && sb[0].cyc == cyc) want = sb.pop_front();
      want_pend = (cyc >= f) ? 8'h04 : 8'h00;
      want_irq  = (cyc >= f + 1);
      checks++;
      if (bus.rise_o !== want.rise || bus.fall_o !== want.fall || bus.event_o !== want.evt ||
          bus.pending_o !== want_pend || bus.irq_o !== want_irq) begin
        errors++;
        $display("FAIL mode_irq cyc=%0d rise=%h/%h fall=%h/%h event=%h/%h pending=%h/%h irq=%b/%b (got/required)",
                 cyc, bus.rise_o, want.rise, bus.fall_o, want.fall, bus.event_o, want.evt,
                 bus.pending_o, want_pend, bus.irq_o, want_irq);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL mode_irq_timeout pending_expectations=%0d required 0", sb.size());
      sb.delete();
    end
    $display("test_mode_irq done cyc=%0d", cyc);
  endtask

  task automatic test_set_clear_race();
    exp_t want;
    int n, f, k2;
    logic [7:0] want_pend;
    logic want_irq;
    n  = cyc;
    f  = n + HOLD + 2 + LAT;
    k2 = HOLD + 2 + LAT + 3;
    sb_push(n + LAT, 8'h04, 8'h00, 8'h00);
    sb_push(f, 8'h00, 8'h04, 8'h04);
    for (int k = 0; k < k2 + 4; k++) begin
      if (k == 0) bus.din[2] = 1'b1;
      if (k == HOLD + 2) bus.din[2] = 1'b0;
      if (k == HOLD + 1 + LAT) bus.clr[2] = 1'b1;   // lands on the event edge
      if (k == HOLD + 2 + LAT) bus.clr[2] = 1'b0;
      if (k == k2) bus.clr[2] = 1'b1;               // clear alone
      if (k == k2 + 1) bus.clr[2] = 1'b0;
      tick();
      want = '{cyc, 8'h00, 8'h00, 8'h00};
      if (sb.size() > 0 && sb[0].cyc == cyc) want = sb.pop_front();
      want_pend = (cyc <= n + k2) ? 8'h04 : 8'h00;
      want_irq  = (cyc <= n + k2 + 1);
      checks++;
      if (bus.rise_o !== want.rise || bus.fall_o !== want.fall || bus.event_o !== want.evt ||
          bus.pending_o !== want_pend || bus.irq_o !== want_irq) begin
        errors++;
        $display("FAIL set_clear cyc=%0d rise=%h/%h fall=%h/%h event=%h/%h pending=%h/%h irq=%b/%b (got/required)",
                 cyc, bus.rise_o, want.rise, bus.fall_o, want.fall, bus.event_o, want.evt,
                 bus.pending_o, want_pend, bus.irq_o, want_irq);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL set_clear_timeout pending_expectations=%0d required 0", sb.size());
      sb.delete();
    end
    bus.irq_en = 8'h00;
    $display("test_set_clear_race done cyc=%0d", cyc);
  endtask

  task automatic test_back_to_back();
    exp_t want;
    int n;
    bus.mode[13:12] = 2'b00;   // ch6 off: edges pulse, no events
    bus.mode[15:14] = 2'b01;   // ch7 rising only
    n = cyc;
    sb_push(n + LAT, 8'h40, 8'h00, 8'h00);
    sb_push(n + HOLD + LAT, 8'h00, 8'h40, 8'h00);
    sb_push(n + 2 * HOLD + LAT, 8'h40, 8'h00, 8'h00);
    sb_push(n + 3 * HOLD + LAT, 8'h00, 8'h40, 8'h00);
    // single-cycle pulse on ch7 only survives without the filter
    if (FILT <= 1) begin
      sb_push(n + LAT, 8'h80, 8'h00, 8'h80);
      sb_push(n + 1 + LAT, 8'h00, 8'h80, 8'h00);
    end
    for (int k = 0; k < 3 * HOLD + LAT + 4; k++) begin
      if (k == 0) begin
        bus.din[6] = 1'b1;
        bus.din[7] = 1'b1;
      end
      if (k == 1) bus.din[7] = 1'b0;
      if (k == HOLD) bus.din[6] = 1'b0;
      if (k == 2 * HOLD) bus.din[6] = 1'b1;
      if (k == 3 * HOLD) bus.din[6] = 1'b0;
      tick();
      want = '{cyc, 8'h00, 8'h00, 8'h00};
      if (sb.size() > 0 && sb[0].cyc == cyc) want = sb.pop_front();
      checks++;
      if (bus.rise_o !== want.rise || bus.fall_o !== want.fall || bus.event_o !== want.evt) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d rise=%h/%h fall=%h/%h event=%h/%h (got/required)",
                 cyc, bus.rise_o, want.rise, bus.fall_o, want.fall, bus.event_o, want.evt);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL back_to_back_timeout pending_expectations=%0d required 0", sb.size());
      sb.delete();
    end
    checks++;
    if (bus.pending_o !== ((FILT <= 1) ? 8'h80 : 8'h00)) begin
      errors++;
      $display("FAIL back_to_back_pending pending=%h required %h", bus.pending_o,
               ((FILT <= 1) ? 8'h80 : 8'h00));
    end
    $display("test_back_to_back done cyc=%0d", cyc);
  endtask

  task automatic test_mid_reset();
    exp_t want;
    int n;
    n = cyc;
    sb_push(n + LAT, 8'h20, 8'h00, 8'h20);
    for (int k = 0; k < LAT + 1; k++) begin
      if (k == 0) bus.din[5] = 1'b1;
      if (k == LAT) rst = 1'b1;   // reset on the edge right after the pulse
      tick();
      want = '{cyc, 8'h00, 8'h00, 8'h00};
      if (sb.size() > 0 && sb[0].cyc == cyc) want = sb.pop_front();
      checks++;
      if (bus.rise_o !== want.rise || bus.fall_o !== want.fall || bus.event_o !== want.evt) begin
        errors++;
        $display("FAIL mid_reset cyc=%0d rise=%h/%h fall=%h/%h event=%h/%h (got/required)",
                 cyc, bus.rise_o, want.rise, bus.fall_o, want.fall, bus.event_o, want.evt);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL mid_reset_timeout pending_expectations=%0d required 0", sb.size());
      sb.delete();
    end
    checks++;
    if (bus.level_o !== 8'h00 || bus.pending_o !== 8'h00 || bus.irq_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_clear level=%h pending=%h irq=%b required all 0",
               bus.level_o, bus.pending_o, bus.irq_o);
    end
    repeat (2) tick();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      want = '{cyc, 8'h00, 8'h00, 8'h00};
      if (sb.size() > 0 && sb[0].cyc == cyc) want = sb.pop_front();
      checks++;
      if (bus.rise_o !== want.rise || bus.fall_o !== want.fall || bus.event_o !== want.evt) begin
        errors++;
        $display("FAIL reprime cyc=%0d rise=%h/%h fall=%h/%h event=%h/%h (got/required)",
                 cyc, bus.rise_o, want.rise, bus.fall_o, want.fall, bus.event_o, want.evt);
      end
    end
    checks++;
    if (bus.level_o !== 8'h29 || bus.pending_o !== 8'h00) begin
      errors++;
      $display("FAIL reprime_state level=%h/29 pending=%h/00 (got/required)", bus.level_o, bus.pending_o);
    end
    $display("test_mid_reset done cyc=%0d", cyc);
  endtask

  initial begin
    test_reset();
    test_single_rise();
    test_glitch();
    test_mode_irq();
    test_set_clear_race();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_edge_detect.md
# multi_edge_detect

Parametrised multi-channel edge detector with input synchronisation, optional glitch filtering, per-channel edge-mode selection and sticky pending flags with an interrupt output. It sits between asynchronous external pins (SPI chip-select, GPIO, button lines) and the control logic, replacing per-signal single-bit detectors with one block that drives a status/interrupt register.

## Interface
- CH, 8, number of independent channels (1..32)
- SYNC_STAGES, 2, synchroniser flops per channel (≥2)
- FILTER_CYCLES, 4, consecutive cycles a new level must persist before acceptance (≥1, only with filter compiled in)
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- din  input  CH  asynchronous channel inputs
- mode  input  2*CH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
- irq_en  input  CH  per-channel interrupt enable
- clr  input  CH  write-1-to-clear strobe for pending bits
- level_o  output  CH  filtered, synchronised level
- rise_o  output  CH  one-cycle pulse on accepted rising edge (mode-independent)
- fall_o  output  CH  one-cycle pulse on accepted falling edge (mode-independent)
- event_o  output  CH  one-cycle pulse on edge matching mode
- pending_o  output  CH  sticky event flags
- irq_o  output  1  OR of (pending_o & irq_en), registered

## Operation
- Reset (rst high at an edge): synchroniser, level, filter counters, primed flag, all outputs to 0.
- Synchroniser: SYNC_STAGES-deep flop chain per channel; output s[i].
- Priming: at edge SYNC_STAGES+1 after rst release, level[i] <= s[i] for all channels, primed <= 1, no pulses generated. Before primed, rise/fall/event/pending stay 0.
- Filter (per channel, counter width clog2(FILTER_CYCLES), saturating not needed): each edge with s != level: if cnt == FILTER_CYCLES-1 then level <= s, cnt <= 0; else cnt++. Any edge with s == level: cnt <= 0 (glitch discarded).
- Edge pulses: registered; rise_o[i]=1 for exactly one cycle after the edge at which level[i] went 0->1; fall_o likewise for 1->0.
- event_o[i] = registered (rise & mode[2i]) | (fall & mode[2i+1]); aligned with rise_o/fall_o.
- pending[i]: set on the edge that asserts event_o[i]; cleared by clr[i]=1; set and clear same cycle -> set wins (stays 1).
- irq_o updated one edge after pending/irq_en change.
- mode change takes effect on the next accepted edge; does not alter pending.

## Timing
- din change settling before edge 1 (relative, post-prime): s changes after edge SYNC_STAGES; level after edge SYNC_STAGES+FILTER_CYCLES; rise/fall/event/pending after edge SYNC_STAGES+FILTER_CYCLES+1; irq_o one edge later.
- Filter disabled: level_o = s (wire); pulses after edge SYNC_STAGES+1.
- Minimum accepted pulse width: FILTER_CYCLES clock periods after synchronisation; shorter pulses produce no output.
- Back-to-back accepted edges on one channel produce separate pulses, minimum spacing FILTER_CYCLES cycles.
- rst asserted mid-filter or mid-pulse: everything to 0 on that edge, re-prime required.

## Configuration
- MULTI_EDGE_FILTER_EN defined: glitch filter and counters built, FILTER_CYCLES honoured.
- Undefined: no counters; level follows synchroniser output directly; FILTER_CYCLES ignored; all other behaviour identical.

## Test plan
- CH=8, SYNC=2, FILTER=4, din=0x00 through reset, release, din[0] 0->1 -> rise_o[0] single pulse 7 edges after change, level_o[0]=1, no other channel toggles.
- din[3]=1 held through reset -> level_o[3]=1 after priming, no rise_o/event_o/pending on channel 3.
- din[1] high for 3 cycles then low (FILTER=4) -> no level change, no pulses; 4 cycles high -> rise accepted.
- mode[5:4]=10, irq_en[2]=1: rising then falling on din[2] -> rise_o and fall_o both pulse, event_o/pending only on falling, irq_o=1 one edge after pending.
- pending[2]=1, new event coincident with clr[2]=1 -> pending stays 1; next clr alone -> 0, irq_o 0 one edge later.
- Build without MULTI_EDGE_FILTER_EN: 1-cycle din[7] pulse (held across a sampling edge) -> rise_o[7] and fall_o[7] each pulse once, rise 3 edges after change.
